// File: rtl/dma_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dma_ctrl_pkg
// Shared definitions for the single-channel copy DMA controller.
//   - Default bus widths for dma_ctrl.
//   - 3-bit FSM state encodings used by dma_ctrl and dma_ctrl_fsm.
// ----------------------------------------------------------------------------
package dma_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 64;

    // State encodings are fixed values so that existing debug scripts and
    // logic analysers that decode the raw state bits keep working.
    localparam logic [2:0] IDLE = 3'd0;  // waiting for start
    localparam logic [2:0] RD   = 3'd1;  // read address phase
    localparam logic [2:0] CAP  = 3'd2;  // capture read data from the bus
    localparam logic [2:0] WR   = 3'd3;  // write phase
    localparam logic [2:0] DONE = 3'd4;  // one-cycle completion

endpackage

// File: rtl/dma_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// dma_ctrl_fsm
// State register and next-state logic of the DMA controller.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   transfer launch pulse (only honoured in IDLE)
//   size_zero  in   the size presented with start is zero
//   last_word  in   the word in flight is the final one of the transfer
//   m_grant    in   bus grant; advances RD and WR
//   state      out  current registered state
// ----------------------------------------------------------------------------
module dma_ctrl_fsm
    import dma_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       size_zero,
    input  logic       last_word,
    input  logic       m_grant,
    output logic [2:0] state
);

    logic [2:0] state_next;

    // NOTE: every variable written in always_comb gets a default first, so
    // paths that do not assign it cannot infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = size_zero ? DONE : RD;
            RD:   if (m_grant) state_next = CAP;
            // Read data is already in flight, so capture never stalls.
            CAP:  state_next = WR;
            WR:   if (m_grant) state_next = last_word ? DONE : RD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

endmodule

// File: rtl/dma_ctrl.sv
// ----------------------------------------------------------------------------
// dma_ctrl
// Single-channel memory-to-memory copy DMA. Each word costs a read address
// phase (RD), a data capture phase (CAP) and a write phase (WR); RD and WR
// stall while the arbiter withholds the grant. All outputs are decoded from
// registered state only.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   transfer launch pulse, sampled in IDLE only
//   src_addr   in   first source word address
//   dst_addr   in   first destination word address
//   size       in   word count (0 = complete immediately, no bus traffic)
//   m_req      out  bus request
//   m_wr       out  bus write strobe (1 = write, 0 = read)
//   m_address  out  bus address
//   m_dout     out  bus write data (always the data register)
//   m_grant    in   arbiter grant
//   m_din      in   bus read data, valid the cycle after the read address
//   busy       out  transfer in progress, including the DONE cycle
//   done       out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        size,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din,
    output logic              busy,
    output logic              done
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [7:0]        count_q;
    logic [DATA_W-1:0] data_q;

    logic size_zero;
    logic last_word;
    logic load;
    logic advance;

    assign size_zero = (size == 8'd0);
    // The decrement in WR reaches zero exactly when one word remains.
    assign last_word = (count_q == 8'd1);
    assign load      = (state == IDLE) && start && !size_zero;
    assign advance   = (state == WR) && m_grant;

    dma_ctrl_fsm u_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .size_zero (size_zero),
        .last_word (last_word),
        .m_grant   (m_grant),
        .state     (state)
    );

    // NOTE: the data register is reset along with the address/count
    // registers so m_dout is a defined zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            if (load) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                count_q <= size;
            end
            // Slave select is registered, so the word addressed in RD is on
            // m_din during CAP whether or not the grant is still held.
            if (state == CAP) data_q <= m_din;
            if (advance) begin
                // Address arithmetic wraps naturally at ADDR_W bits.
                src_q   <= src_q + ADDR_W'(1);
                dst_q   <= dst_q + ADDR_W'(1);
                count_q <= count_q - 8'd1;
            end
        end
    end

    // Moore output decode: nothing here depends on m_grant or m_din.
    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        case (state)
            RD: begin
                m_req     = 1'b1;
                m_address = src_q;
            end
            CAP: m_req = 1'b1;
            WR: begin
                m_req     = 1'b1;
                m_wr      = 1'b1;
                m_address = dst_q;
            end
            default: ;
        endcase
    end

    assign m_dout = data_q;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, bus address width; SHALL match the bus address width.
REQ-002 Parameter DATA_W, default 64, bus data width; SHALL match the bus data width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  first source word address; latched on an accepted start.
REQ-007 dst_addr  input  ADDR_W  first destination word address; latched on an accepted start.
REQ-008 size  input  8  word count; latched on an accepted start.
REQ-009 m_req  output  1  bus request to the arbiter.
REQ-010 m_wr  output  1  bus write strobe; 1 = write, 0 = read.
REQ-011 m_address  output  ADDR_W  bus address.
REQ-012 m_dout  output  DATA_W  write data to the bus.
REQ-013 m_grant  input  1  arbiter grant for this master.
REQ-014 m_din  input  DATA_W  read data from the bus; valid the cycle after the read address phase, because slave select is registered.
REQ-015 busy  output  1  high from start acceptance until the DONE state is exited.
REQ-016 done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-017 FSM states: IDLE, RD (read address phase), CAP (capture read data), WR (write phase), DONE.
REQ-018 IDLE: start=1 with size!=0 -> latch src, dst and count=size; go to RD. start=1 with size=0 -> go directly to DONE; no bus traffic.
REQ-019 start while not in IDLE SHALL be ignored; latched values SHALL be unchanged.
REQ-020 m_req SHALL be 1 in RD, CAP and WR, and 0 in IDLE and DONE.
REQ-021 RD: drive m_wr=0 and m_address=src; if m_grant=1 go to CAP, else stay in RD (stall).
REQ-022 CAP: latch m_din into the data register unconditionally (data already in flight); drive m_wr=0 and m_address=0; go to WR.
REQ-023 WR: drive m_wr=1, m_address=dst, m_dout=data register; if m_grant=1 then src+=1, dst+=1, count-=1, and go to RD if the new count!=0, else to DONE; if m_grant=0 stay in WR.
REQ-024 Address increments SHALL wrap modulo 2^ADDR_W (0xFF+1 -> 0x00).
REQ-025 Minimum cost is 3 granted cycles per word, so a transfer of N words takes 3N cycles plus one DONE cycle with no stalls.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE; busy=1 in DONE.
REQ-027 Outside WR, m_wr SHALL be 0; m_dout SHALL always equal the data register.
REQ-028 Outputs SHALL be decoded from registered state only (Moore); there is no combinational path from m_grant or m_din to any output.

Reset
REQ-029 reset_n=0 SHALL force, asynchronously, state=IDLE; m_req, m_wr, busy and done to 0; m_address, m_dout, and the src, dst, count and data registers to 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-031 A shared package SHALL hold the state encodings (3-bit constants IDLE=0, RD=1, CAP=2, WR=3, DONE=4) and the ADDR_W/DATA_W defaults.
REQ-032 The next-state logic SHALL be one sub-module, dma_ctrl_fsm; the datapath registers SHALL stay in dma_ctrl and use async-reset flip-flops.

Verification
REQ-033 Bench SHALL cover: m_grant held 1; start with src=0x10, dst=0x80, size=2; slave returns 0xA, 0xB -> writes 0x80<=0xA then 0x81<=0xB; done pulses at cycle 7 after start.
REQ-034 Bench SHALL cover: start with size=0 -> m_req stays 0; done pulses on the next cycle; busy high for exactly 1 cycle.
REQ-035 Bench SHALL cover: m_grant=0 for 4 cycles during RD, then again during WR -> FSM holds state and address, and the data written is unchanged.
REQ-036 Bench SHALL cover: src=0xFF, dst=0xFE, size=3 -> reads 0xFF, 0x00, 0x01 and writes 0xFE, 0xFF, 0x00.
REQ-037 Bench SHALL cover: second start pulse during busy -> ignored; the original transfer completes unchanged.
REQ-038 Bench SHALL cover: reset_n pulsed low in CAP -> all outputs 0 immediately and no done pulse; a following start with size=1 completes normally.
